// File: rtl/fe_redirect_sequencer.sv
// fe_redirect_sequencer
//   Frontend redirect controller. Arbitrates three redirect sources by priority
//   (ROB > predecode > BPU/trap), holds the frontend flush for FLUSH_CYCLES
//   cycles, then presents the new fetch PC to PC-gen with a valid/ready
//   handshake. A strictly higher priority request (or any new ROB request)
//   preempts a redirect that is still flushing or waiting to issue.
//
// Parameters
//   PC_W          fetch PC width
//   FLUSH_CYCLES  cycles the flush is held (1..15)
//   CNT_W         flush counter width (must hold FLUSH_CYCLES-1)
//
// Ports
//   Clk, Rest                clock, asynchronous active-low reset
//   RobRedir/RobRedirPc      ROB commit redirect request and target
//   PreRedir/PreRedirPc      predecode redirect request and target
//   BpRedir/BpRedirPc        BPU / ICache-trap redirect request and target
//   FrontStall               frontend stall (blocks the PC-gen handshake)
//   PcReady                  PC-gen accepts a redirect
//   FlushAll                 flush whole frontend incl. FTQ/predecode (ROB only)
//   FlushFront               flush PC/BTB/TAGE/ICache stages (every source)
//   RedirValid/RedirPc       redirect offered to PC-gen, PC[1:0] forced to 0
//   RedirSrc                 0 none, 1 BP, 2 Pre, 3 ROB
//   Busy                     controller not idle
//
// Optional feature (macro FE_REDIR_PERF_EN)
//   Adds saturating 32-bit counters PerfRobCnt, PerfPreCnt, PerfBpCnt (requests
//   latched per source) and PerfPreemptCnt (preemptions).

module fe_redirect_sequencer #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            RobRedir,
  input  logic [PC_W-1:0] RobRedirPc,
  input  logic            PreRedir,
  input  logic [PC_W-1:0] PreRedirPc,
  input  logic            BpRedir,
  input  logic [PC_W-1:0] BpRedirPc,
  input  logic            FrontStall,
  input  logic            PcReady,
  output logic            FlushAll,
  output logic            FlushFront,
  output logic            RedirValid,
  output logic [PC_W-1:0] RedirPc,
  output logic [1:0]      RedirSrc,
  output logic            Busy
`ifdef FE_REDIR_PERF_EN
  ,
  output logic [31:0]     PerfRobCnt,
  output logic [31:0]     PerfPreCnt,
  output logic [31:0]     PerfBpCnt,
  output logic [31:0]     PerfPreemptCnt
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StIssue = 2'd2
  } stateT;

  // Source codes double as priority: a larger code wins.
  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcBp   = 2'd1;
  localparam logic [1:0] SrcPre  = 2'd2;
  localparam logic [1:0] SrcRob  = 2'd3;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0]  PcMask  = {{(PC_W-2){1'b1}}, 2'b00};

  stateT            state;
  stateT            stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [1:0]       reqSrc;
  logic [PC_W-1:0]  reqPc;
  logic             reqAny;
  logic             preempt;
  logic             handshake;
  logic             latch;
  logic [1:0]       srcNext;
  logic [PC_W-1:0]  pcNext;

  always_comb begin
    reqSrc = SrcNone;
    reqPc  = '0;
    if (RobRedir) begin
      reqSrc = SrcRob;
      reqPc  = RobRedirPc;
    end else if (PreRedir) begin
      reqSrc = SrcPre;
      reqPc  = PreRedirPc;
    end else if (BpRedir) begin
      reqSrc = SrcBp;
      reqPc  = BpRedirPc;
    end
  end

  assign reqAny    = (reqSrc != SrcNone);
  assign handshake = PcReady && !FrontStall;
  // RedirSrc holds the latched source whenever the controller is busy.
  assign preempt   = (state != StIdle) && reqAny &&
                     ((reqSrc == SrcRob) || (reqSrc > RedirSrc));

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    srcNext   = RedirSrc;
    pcNext    = RedirPc;
    latch     = 1'b0;
    case (state)
      StIdle: begin
        latch = reqAny;
      end
      StFlush: begin
        if (preempt) begin
          latch = 1'b1;
        end else if (cnt == '0) begin
          stateNext = StIssue;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      StIssue: begin
        // Preemption beats the handshake; a request arriving on the handshake
        // cycle is taken as a fresh redirect without passing through idle.
        if (preempt || (handshake && reqAny)) begin
          latch = 1'b1;
        end else if (handshake) begin
          stateNext = StIdle;
          srcNext   = SrcNone;
        end
      end
      default: begin
        stateNext = StIdle;
      end
    endcase
    if (latch) begin
      stateNext = StFlush;
      cntNext   = CntLoad;
      srcNext   = reqSrc;
      pcNext    = reqPc & PcMask;
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state      <= StIdle;
      cnt        <= '0;
      FlushAll   <= 1'b0;
      FlushFront <= 1'b0;
      RedirValid <= 1'b0;
      RedirPc    <= '0;
      RedirSrc   <= SrcNone;
      Busy       <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      FlushAll   <= (stateNext == StFlush) && (srcNext == SrcRob);
      FlushFront <= (stateNext == StFlush);
      RedirValid <= (stateNext == StIssue);
      RedirPc    <= pcNext;
      RedirSrc   <= srcNext;
      Busy       <= (stateNext != StIdle);
    end
  end

`ifdef FE_REDIR_PERF_EN
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      PerfRobCnt     <= '0;
      PerfPreCnt     <= '0;
      PerfBpCnt      <= '0;
      PerfPreemptCnt <= '0;
    end else begin
      if (latch && (reqSrc == SrcRob) && (PerfRobCnt != '1)) begin
        PerfRobCnt <= PerfRobCnt + 32'd1;
      end
      if (latch && (reqSrc == SrcPre) && (PerfPreCnt != '1)) begin
        PerfPreCnt <= PerfPreCnt + 32'd1;
      end
      if (latch && (reqSrc == SrcBp) && (PerfBpCnt != '1)) begin
        PerfBpCnt <= PerfBpCnt + 32'd1;
      end
      if (preempt && (PerfPreemptCnt != '1)) begin
        PerfPreemptCnt <= PerfPreemptCnt + 32'd1;
      end
    end
  end
`endif

endmodule
